pe_stream_driver: RTL

//  Initiator side of the PE operand/result interface. Accepts a job command and fetches N activation/weight pairs

---
 rtl/pe_stream_driver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_stream_driver.sv
// Initiator between the tile controller and one PE: fetches N activation/weight
// pairs from SRAM, streams them to the PE and writes the returned results back.
module pe_stream_driver #(
  parameter int DATA_WIDTH      = 16,
  parameter int ACC_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int LEN_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_act_base,
  input  logic [ADDR_WIDTH-1:0] cmd_wgt_base,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  act_rd_en,
  output logic [ADDR_WIDTH-1:0] act_rd_addr,
  input  logic [DATA_WIDTH-1:0] act_rd_data,
  output logic                  wgt_rd_en,
  output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
  input  logic [DATA_WIDTH-1:0] wgt_rd_data,
  output logic [DATA_WIDTH-1:0] pe_input_data,
  output logic                  pe_input_valid,
  input  logic                  pe_input_ready,
  output logic [DATA_WIDTH-1:0] pe_weight_data,
  output logic                  pe_weight_valid,
  input  logic                  pe_weight_ready,
  input  logic [ACC_WIDTH-1:0]  pe_output_data,
  input  logic                  pe_output_valid,
  output logic                  pe_output_ready,
  output logic                  res_wr_en,
  output logic [ADDR_WIDTH-1:0] res_wr_addr,
  output logic [ACC_WIDTH-1:0]  res_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  logic [1:0]            r_state;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_act_base;
  logic [ADDR_WIDTH-1:0] r_wgt_base;
  logic [ADDR_WIDTH-1:0] r_out_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_fetch_cnt;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_recv_cnt;
  logic [1:0]            r_outstanding;
  logic                  r_rd_inflight;
  logic [DATA_WIDTH-1:0] r_fifo_act [2];
  logic [DATA_WIDTH-1:0] r_fifo_wgt [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_count;
  logic                  r_res_wr_en;
  logic [ADDR_WIDTH-1:0] r_res_wr_addr;
  logic [ACC_WIDTH-1:0]  r_res_wr_data;

  logic w_accept;
  logic w_fetch;
  logic w_pe_valid;
  logic w_issue;
  logic w_recv_ready;
  logic w_recv;

  assign w_accept = cmd_valid && r_cmd_ready;

  // A new read is only issued when the FIFO is guaranteed a free slot for its data.
  assign w_fetch = (r_state == S_RUN) && (r_fetch_cnt != r_len) &&
                   ((r_fifo_count + {1'b0, r_rd_inflight}) < 2'd2);

  assign w_pe_valid   = (r_state == S_RUN) && (r_fifo_count != 2'd0) && (r_outstanding < MAX_OUT);
  assign w_issue      = w_pe_valid && pe_input_ready && pe_weight_ready;
  assign w_recv_ready = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_recv_cnt != r_len);
  assign w_recv       = w_recv_ready && pe_output_valid;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_act_base    <= '0;
      r_wgt_base    <= '0;
      r_out_base    <= '0;
      r_len         <= '0;
      r_fetch_cnt   <= '0;
      r_issue_cnt   <= '0;
      r_recv_cnt    <= '0;
      r_outstanding <= '0;
      r_rd_inflight <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_fifo_count  <= '0;
      r_res_wr_en   <= 1'b0;
      r_res_wr_addr <= '0;
      r_res_wr_data <= '0;
      // NOTE: the two operand slots are cleared here because they drive the PE data
      // ports directly, which must read zero while in reset.
      for (int i = 0; i < 2; i++) begin
        r_fifo_act[i] <= '0;
        r_fifo_wgt[i] <= '0;
      end
    end else begin
      // Ready drops for the done cycle, so a command then is never taken.
      r_cmd_ready <= (r_state == S_IDLE) && !w_accept;
      r_done      <= (r_state == S_DONE);
      if (r_done) begin
        r_busy <= 1'b0;
      end

      r_rd_inflight <= w_fetch;
      if (w_fetch) begin
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      end

      if (r_rd_inflight) begin
        r_fifo_act[r_wr_ptr] <= act_rd_data;
        r_fifo_wgt[r_wr_ptr] <= wgt_rd_data;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_issue) begin
        r_rd_ptr    <= ~r_rd_ptr;
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      case ({r_rd_inflight, w_issue})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: ;
      endcase

      case ({w_issue, w_recv})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: ;
      endcase

      r_res_wr_en <= w_recv;
      if (w_recv) begin
        r_res_wr_addr <= r_out_base + ADDR_WIDTH'(r_recv_cnt);
        r_res_wr_data <= pe_output_data;
        r_recv_cnt    <= r_recv_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_act_base    <= cmd_act_base;
            r_wgt_base    <= cmd_wgt_base;
            r_out_base    <= cmd_out_base;
            r_len         <= cmd_len;
            r_fetch_cnt   <= '0;
            r_issue_cnt   <= '0;
            r_recv_cnt    <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b1;
            r_state       <= (cmd_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if ((r_fetch_cnt == r_len) && (r_issue_cnt == r_len)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_recv_cnt == r_len) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign act_rd_en       = w_fetch;
  assign wgt_rd_en       = w_fetch;
  assign act_rd_addr     = r_act_base + ADDR_WIDTH'(r_fetch_cnt);
  assign wgt_rd_addr     = r_wgt_base + ADDR_WIDTH'(r_fetch_cnt);
  assign pe_input_data   = r_fifo_act[r_rd_ptr];
  assign pe_weight_data  = r_fifo_wgt[r_rd_ptr];
  assign pe_input_valid  = w_pe_valid;
  assign pe_weight_valid = w_pe_valid;
  assign pe_output_ready = w_recv_ready;
  assign res_wr_en       = r_res_wr_en;
  assign res_wr_addr     = r_res_wr_addr;
  assign res_wr_data     = r_res_wr_data;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
